// File: rtl/bus_arb_pkg.sv
// Shared types, mode constants and packet helpers for the multi-lane bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_ROUTE = 2'd2,
    ST_PUSH  = 2'd3
  } lane_state_t;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;
  localparam int ADDR_W     = 8;
  localparam int MAX_PKT_W  = 256;

  // Destination address sits in the top ADDR_W bits of a pkt_w-wide packet.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [MAX_PKT_W-1:0] pkt,
                                                 input int                   pkt_w);
    return pkt[8'(pkt_w - 1) -: ADDR_W];
  endfunction

endpackage

// File: rtl/bus_lane_fsm.sv
// One bus lane: picks a pending device, pops its head packet and pushes it to
// the addressed device, or to every other device on broadcast.
module bus_lane_fsm
  import bus_arb_pkg::*;
#(
  parameter int                drvrs     = 4,
  parameter int                pckg_sz   = 16,
  parameter logic [ADDR_W-1:0] broadcast = 8'hFF,
  parameter int                MODE      = MODE_RR
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  input  logic [drvrs-1:0]                full,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [pckg_sz-1:0]              D_push,
  output logic                            busy,
  output logic                            drop
);

  localparam int IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

  lane_state_t         state_reg;
  logic [IDX_W-1:0]    rr_reg;
  logic [IDX_W-1:0]    src_reg;
  logic [pckg_sz-1:0]  pkt_reg;
  logic [drvrs-1:0]    mask_reg;
  logic [drvrs-1:0]    pop_reg;
  logic [drvrs-1:0]    push_reg;
  logic [pckg_sz-1:0]  d_push_reg;
  logic                busy_reg;
  logic                drop_reg;

  logic [IDX_W-1:0]    base_idx;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    rr_next;
  logic                grant_valid;
  logic [ADDR_W-1:0]   dst;
  logic [drvrs-1:0]    route_mask;
  int                  scan_idx;

  assign base_idx = (MODE == MODE_FIXED) ? '0 : rr_reg;

  // Scan from the far end back toward base_idx so the last hit is the first
  // pending device at or after base_idx in wrap-around order.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = drvrs - 1; k >= 0; k--) begin
      scan_idx = int'(base_idx) + k;
      if (scan_idx >= drvrs) begin
        scan_idx = scan_idx - drvrs;
      end
      if (pndng[IDX_W'(scan_idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(scan_idx);
      end
    end
  end

  assign rr_next = (int'(grant_idx) == drvrs - 1) ? '0 : grant_idx + 1'b1;

  assign dst = addr_of(MAX_PKT_W'(pkt_reg), pckg_sz);

  // An empty mask means the packet cannot be delivered and is dropped.
  always_comb begin
    route_mask = '0;
    for (int k = 0; k < drvrs; k++) begin
      if (dst == broadcast) begin
        route_mask[k] = (k != int'(src_reg));
      end else begin
        route_mask[k] = (int'(dst) == k) && (k != int'(src_reg));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      rr_reg     <= '0;
      src_reg    <= '0;
      pkt_reg    <= '0;
      mask_reg   <= '0;
      pop_reg    <= '0;
      push_reg   <= '0;
      d_push_reg <= '0;
      busy_reg   <= 1'b0;
      drop_reg   <= 1'b0;
    end else begin
      pop_reg  <= '0;
      push_reg <= '0;
      drop_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            src_reg   <= grant_idx;
            state_reg <= ST_POP;
            busy_reg  <= 1'b1;
            if (MODE == MODE_RR) begin
              rr_reg <= rr_next;
            end
          end
        end
        ST_POP: begin
          pop_reg[src_reg] <= 1'b1;
          pkt_reg          <= D_pop[src_reg];
          state_reg        <= ST_ROUTE;
        end
        ST_ROUTE: begin
          mask_reg <= route_mask;
          if (|route_mask) begin
            state_reg <= ST_PUSH;
          end else begin
            drop_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        ST_PUSH: begin
          // Broadcast waits until every destination can accept at once.
          if ((full & mask_reg) == '0) begin
            push_reg   <= mask_reg;
            d_push_reg <= pkt_reg;
            busy_reg   <= 1'b0;
            state_reg  <= ST_IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign pop    = pop_reg;
  assign push   = push_reg;
  assign D_push = d_push_reg;
  assign busy   = busy_reg;
  assign drop   = drop_reg;

endmodule

// File: rtl/bus_lane_arbiter.sv
// Multi-lane bus arbiter: bits independent lanes, each serving drvrs devices
// with round-robin or fixed-priority arbitration.
module bus_lane_arbiter
  import bus_arb_pkg::*;
#(
  parameter int                bits      = 1,
  parameter int                drvrs     = 4,
  parameter int                pckg_sz   = 16,
  parameter logic [ADDR_W-1:0] broadcast = 8'hFF,
  parameter int                MODE      = MODE_RR
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [bits-1:0][drvrs-1:0]              pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  input  logic [bits-1:0][drvrs-1:0]              full,
  output logic [bits-1:0][drvrs-1:0]              pop,
  output logic [bits-1:0][drvrs-1:0]              push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push,
  output logic [bits-1:0]                         busy,
  output logic [bits-1:0]                         drop
);

  generate
    for (genvar gi = 0; gi < bits; gi++) begin : g_lane
      logic [pckg_sz-1:0] lane_d_push;

      bus_lane_fsm #(
        .drvrs     (drvrs),
        .pckg_sz   (pckg_sz),
        .broadcast (broadcast),
        .MODE      (MODE)
      ) u_lane (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng[gi]),
        .D_pop  (D_pop[gi]),
        .full   (full[gi]),
        .pop    (pop[gi]),
        .push   (push[gi]),
        .D_push (lane_d_push),
        .busy   (busy[gi]),
        .drop   (drop[gi])
      );

      // Every device on a lane sees the same outgoing packet.
      for (genvar gj = 0; gj < drvrs; gj++) begin : g_dev
        assign D_push[gi][gj] = lane_d_push;
      end
    end
  endgenerate

endmodule

// File: tb/tb_bus_lane_arbiter.sv
// Bench: two arbiter instances (2-lane round-robin, 1-lane fixed priority)
// checked every cycle against a transaction-level model, plus directed pins.
module tb_bus_lane_arbiter;

  localparam int D  = 4;
  localparam int W  = 16;
  localparam int NL = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][D-1:0]        pndng_a, full_a, pop_a, push_a;
  logic [1:0][D-1:0][W-1:0] dpop_a, dpush_a;
  logic [1:0]               busy_a, drop_a;
  logic [0:0][D-1:0]        pndng_b, full_b, pop_b, push_b;
  logic [0:0][D-1:0][W-1:0] dpop_b, dpush_b;
  logic [0:0]               busy_b, drop_b;

  bus_lane_arbiter #(.bits(2), .drvrs(D), .pckg_sz(W), .broadcast(8'hFF), .MODE(0)) dut_rr (
    .clk(clk), .reset(rst), .pndng(pndng_a), .D_pop(dpop_a), .full(full_a),
    .pop(pop_a), .push(push_a), .D_push(dpush_a), .busy(busy_a), .drop(drop_a));

  bus_lane_arbiter #(.bits(1), .drvrs(D), .pckg_sz(W), .broadcast(8'hFF), .MODE(1)) dut_fp (
    .clk(clk), .reset(rst), .pndng(pndng_b), .D_pop(dpop_b), .full(full_b),
    .pop(pop_b), .push(push_b), .D_push(dpush_b), .busy(busy_b), .drop(drop_b));

  // Logical lanes 0,1 = round-robin instance, lane 2 = fixed-priority instance.
  logic [D-1:0] i_pndng [NL];
  logic [D-1:0] i_full  [NL];
  logic [W-1:0] i_dpop  [NL][D];
  logic [W-1:0] dq      [NL][D][$];

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      pndng_a[l] = i_pndng[l];
      full_a[l]  = i_full[l];
      for (int d = 0; d < D; d++) dpop_a[l][d] = i_dpop[l][d];
    end
    pndng_b[0] = i_pndng[2];
    full_b[0]  = i_full[2];
    for (int d = 0; d < D; d++) dpop_b[0][d] = i_dpop[2][d];
  end

  logic [D-1:0] o_pop [NL];
  logic [D-1:0] o_push[NL];
  logic         o_busy[NL];
  logic         o_drop[NL];
  logic [W-1:0] o_dpush[NL][D];

  // Model state: a transfer is described by its source, packet and the number of edges since grant.
  bit           m_active[NL];
  int           m_age[NL];
  int           m_src[NL];
  int           m_rr[NL];
  logic [W-1:0] m_pkt[NL];
  logic [D-1:0] m_mask[NL];
  logic [D-1:0] exp_pop[NL];
  logic [D-1:0] exp_push[NL];
  logic         exp_drop[NL];
  logic         exp_busy[NL];
  logic [W-1:0] exp_dpush[NL];

  int pop_log[NL][$];
  int n_cmp, n_bad, cyc;

  task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lane %0d cycle %0d: got %h, expected %h", name, lane, cyc, act, exp);
    end
  endtask

  function automatic int pick_winner(input int l, input logic [D-1:0] req);
    int start;
    start = (l == 2) ? 0 : m_rr[l];
    for (int k = 0; k < D; k++) begin
      if (req[(start + k) % D]) return (start + k) % D;
    end
    return -1;
  endfunction

  function automatic logic [D-1:0] dest_mask(input logic [W-1:0] pkt, input int src);
    int a;
    logic [D-1:0] m;
    a = int'(pkt[W-1:W-8]);
    m = '0;
    if (a == 255) begin
      for (int k = 0; k < D; k++) if (k != src) m[k] = 1'b1;
    end else if (a < D && a != src) begin
      m[a] = 1'b1;
    end
    return m;
  endfunction

  task automatic model_step();
    int w;
    for (int l = 0; l < NL; l++) begin
      exp_pop[l]  = '0;
      exp_push[l] = '0;
      exp_drop[l] = 1'b0;
      if (rst) begin
        m_active[l]  = 1'b0;
        m_rr[l]      = 0;
        exp_dpush[l] = '0;
      end else if (!m_active[l]) begin
        w = pick_winner(l, i_pndng[l]);
        if (w >= 0) begin
          m_active[l] = 1'b1;
          m_age[l]    = 0;
          m_src[l]    = w;
          if (l != 2) m_rr[l] = (w + 1) % D;
        end
      end else begin
        m_age[l]++;
        if (m_age[l] == 1) begin
          m_pkt[l]   = i_dpop[l][m_src[l]];
          exp_pop[l] = D'(1) << m_src[l];
        end else if (m_age[l] == 2) begin
          m_mask[l] = dest_mask(m_pkt[l], m_src[l]);
          if (m_mask[l] == '0) begin
            exp_drop[l] = 1'b1;
            m_active[l] = 1'b0;
          end
        end else if ((i_full[l] & m_mask[l]) == '0) begin
          exp_push[l]  = m_mask[l];
          exp_dpush[l] = m_pkt[l];
          m_active[l]  = 1'b0;
        end
      end
      exp_busy[l] = m_active[l];
    end
  endtask

  task automatic drive();
    for (int l = 0; l < NL; l++) begin
      for (int d = 0; d < D; d++) begin
        i_pndng[l][d] = (dq[l][d].size() > 0);
        i_dpop[l][d]  = (dq[l][d].size() > 0) ? dq[l][d][0] : 16'hDEAD;
      end
    end
  endtask

  task automatic enq(input int l, input int d, input logic [W-1:0] pkt);
    dq[l][d].push_back(pkt);
    drive();
  endtask

  task automatic sample();
    for (int l = 0; l < 2; l++) begin
      o_pop[l]  = pop_a[l];
      o_push[l] = push_a[l];
      o_busy[l] = busy_a[l];
      o_drop[l] = drop_a[l];
      for (int d = 0; d < D; d++) o_dpush[l][d] = dpush_a[l][d];
    end
    o_pop[2]  = pop_b[0];
    o_push[2] = push_b[0];
    o_busy[2] = busy_b[0];
    o_drop[2] = drop_b[0];
    for (int d = 0; d < D; d++) o_dpush[2][d] = dpush_b[0][d];
  endtask

  task automatic check_and_react();
    for (int l = 0; l < NL; l++) begin
      chk("pop",  l, 32'(o_pop[l]),  32'(exp_pop[l]));
      chk("push", l, 32'(o_push[l]), 32'(exp_push[l]));
      chk("busy", l, 32'(o_busy[l]), 32'(exp_busy[l]));
      chk("drop", l, 32'(o_drop[l]), 32'(exp_drop[l]));
      if (exp_push[l] != '0) begin
        for (int d = 0; d < D; d++) chk("d_push", l, 32'(o_dpush[l][d]), 32'(exp_dpush[l]));
      end
      if (o_push[l] != '0)
        $display("lane %0d cycle %0d: push mask %b data %h", l, cyc, o_push[l], o_dpush[l][0]);
      if (o_drop[l])
        $display("lane %0d cycle %0d: drop", l, cyc);
      for (int d = 0; d < D; d++) begin
        if (o_pop[l][d] && dq[l][d].size() > 0) begin
          void'(dq[l][d].pop_front());
          pop_log[l].push_back(d);
        end
      end
    end
    drive();
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    sample();
    check_and_react();
  endtask

  function automatic int log_at(input int l, input int k);
    return (k < pop_log[l].size()) ? pop_log[l][k] : -1;
  endfunction

  function automatic logic [W-1:0] rand_pkt();
    int sel;
    logic [7:0] a;
    sel = int'($urandom_range(7));
    if (sel < 4)       a = 8'(sel);
    else if (sel < 6)  a = 8'hFF;
    else if (sel == 6) a = 8'($urandom);
    else               a = 8'($urandom_range(254, 4));
    return {a, 8'($urandom)};
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst   = 1'b1;
    for (int l = 0; l < NL; l++) begin
      i_full[l]    = '0;
      m_active[l]  = 1'b0;
      m_age[l]     = 0;
      m_src[l]     = 0;
      m_rr[l]      = 0;
      m_pkt[l]     = '0;
      m_mask[l]    = '0;
      exp_dpush[l] = '0;
    end
    drive();
    repeat (3) step();

    for (int l = 0; l < NL; l++) begin
      chk("rst_pop",  l, 32'(o_pop[l]),  0);
      chk("rst_push", l, 32'(o_push[l]), 0);
      chk("rst_busy", l, 32'(o_busy[l]), 0);
      chk("rst_drop", l, 32'(o_drop[l]), 0);
      for (int d = 0; d < D; d++) chk("rst_d_push", l, 32'(o_dpush[l][d]), 0);
    end

    // Unicast on lane 0, round-robin rotation on lane 1, fixed priority on lane 2.
    rst = 1'b0;
    enq(0, 1, 16'h02A5);
    enq(1, 0, 16'h0100); enq(1, 1, 16'h0011); enq(1, 2, 16'h0022); enq(1, 3, 16'h0033);
    enq(2, 0, 16'h0140); enq(2, 0, 16'h0241); enq(2, 0, 16'h0342);
    enq(2, 3, 16'h0050); enq(2, 3, 16'h0151);
    step();
    chk("uni_busy", 0, 32'(o_busy[0]), 1);
    step();
    chk("uni_pop", 0, 32'(o_pop[0]), 32'h2);
    chk("fixed_first_pop", 2, 32'(o_pop[2]), 32'h1);
    step();
    chk("uni_no_push_yet", 0, 32'(o_push[0]), 0);
    step();
    chk("uni_push", 0, 32'(o_push[0]), 32'h4);
    chk("uni_data", 0, 32'(o_dpush[0][0]), 32'h02A5);
    chk("uni_drop", 0, 32'(o_drop[0]), 0);
    repeat (20) step();
    for (int k = 0; k < 4; k++) chk("rr_order", 1, 32'(log_at(1, k)), 32'(k));
    for (int k = 0; k < 3; k++) chk("fixed_order", 2, 32'(log_at(2, k)), 0);
    chk("fixed_tail", 2, 32'(log_at(2, 3)), 3);

    // Broadcast from device 2.
    enq(0, 2, 16'hFF3C);
    repeat (3) step();
    chk("bc_no_push_yet", 0, 32'(o_push[0]), 0);
    step();
    chk("bc_push", 0, 32'(o_push[0]), 32'hB);
    chk("bc_data", 0, 32'(o_dpush[0][3]), 32'hFF3C);
    step();
    chk("bc_single", 0, 32'(o_push[0]), 0);

    // Back-pressure on device 3 for ten cycles.
    i_full[0] = 4'b1000;
    enq(0, 0, 16'h03AA);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_busy", 0, 32'(o_busy[0]), 1);
      chk("bp_no_push", 0, 32'(o_push[0]), 0);
    end
    i_full[0] = 4'b0000;
    step();
    chk("bp_push", 0, 32'(o_push[0]), 32'h8);
    chk("bp_data", 0, 32'(o_dpush[0][1]), 32'h03AA);
    chk("bp_idle", 0, 32'(o_busy[0]), 0);

    // Out-of-range then self-addressed packet: two drops, no push.
    enq(0, 0, 16'h0711);
    enq(0, 0, 16'h0022);
    repeat (3) step();
    chk("drop_range", 0, 32'(o_drop[0]), 1);
    step();
    chk("drop_pulse", 0, 32'(o_drop[0]), 0);
    repeat (2) step();
    chk("drop_self", 0, 32'(o_drop[0]), 1);
    chk("drop_no_push", 0, 32'(o_push[0]), 0);
    step();
    chk("drop_idle", 0, 32'(o_busy[0]), 0);

    // Reset while both lanes stall on full.
    i_full[0] = 4'b1000;
    i_full[1] = 4'b0010;
    enq(0, 1, 16'h0377);
    enq(1, 2, 16'h0155);
    repeat (6) step();
    chk("stall_busy", 0, 32'(o_busy[0]), 1);
    chk("stall_busy", 1, 32'(o_busy[1]), 1);
    rst = 1'b1;
    step();
    for (int l = 0; l < 2; l++) begin
      chk("mid_rst_pop",  l, 32'(o_pop[l]),  0);
      chk("mid_rst_push", l, 32'(o_push[l]), 0);
      chk("mid_rst_busy", l, 32'(o_busy[l]), 0);
      chk("mid_rst_drop", l, 32'(o_drop[l]), 0);
    end
    rst = 1'b0;
    i_full[0] = '0;
    i_full[1] = '0;
    step();
    chk("post_rst_idle", 0, 32'(o_busy[0]), 0);
    enq(1, 3, 16'h02BB);
    repeat (4) step();
    chk("post_rst_push", 1, 32'(o_push[1]), 32'h4);
    chk("post_rst_data", 1, 32'(o_dpush[1][2]), 32'h02BB);

    // Randomized traffic, back-pressure and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < NL; l++) begin
        for (int d = 0; d < D; d++) begin
          if ($urandom_range(5) == 0 && dq[l][d].size() < 3) dq[l][d].push_back(rand_pkt());
        end
        if ((c / 150) % 6 == 5) i_full[l] = 4'hF;
        else                    i_full[l] = 4'($urandom & $urandom);
      end
      rst = ($urandom_range(499) == 0);
      drive();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
